// File: rtl/kc705_ethernet_rx_decode_ctrl_pkg.sv
// kc705_eth_ctrl_pkg: shared state, speed and watchdog-scaling definitions for the RX decode sequencer
package kc705_eth_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_WAIT_FRAME = 3'd2,
    ST_IN_FRAME   = 3'd3,
    ST_FLUSH      = 3'd4,
    ST_DONE       = 3'd5
  } state_e;
  localparam logic [1:0] SPEED_1G   = 2'b10;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [2:0] SHIFT_1G   = 3'd0;
  localparam logic [2:0] SHIFT_100M = 3'd4;
  localparam logic [2:0] SHIFT_10M  = 3'd7;
  // 2'b11 is treated as 10M, so anything that is not 1G or 100M gets the slowest scaling
  function automatic logic [2:0] wdog_shift(input logic [1:0] speed);
    return speed == SPEED_1G ? SHIFT_1G : speed == SPEED_100M ? SHIFT_100M : SHIFT_10M;
  endfunction
endpackage

// File: rtl/kc705_ethernet_rx_decode_ctrl_if.sv
// kc705_ethernet_rx_decode_ctrl_if: control, decoder snoop and status bundle of the RX decode sequencer
interface kc705_ethernet_rx_decode_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic [1:0]           speed;
  logic                 ctrl_start;
  logic                 ctrl_stop;
  logic [CNT_WIDTH-1:0] ctrl_num_frames;
  logic                 dec_tvalid;
  logic                 dec_tlast;
  logic                 dec_tready;
  logic                 enable_rx_decode;
  logic                 decoder_resetn;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] frames_ok;
  logic [CNT_WIDTH-1:0] frames_timeout;
  modport master (
    output speed, ctrl_start, ctrl_stop, ctrl_num_frames, dec_tvalid, dec_tlast, dec_tready,
    input  enable_rx_decode, decoder_resetn, busy, done, frames_ok, frames_timeout
  );
  modport slave (
    input  speed, ctrl_start, ctrl_stop, ctrl_num_frames, dec_tvalid, dec_tlast, dec_tready,
    output enable_rx_decode, decoder_resetn, busy, done, frames_ok, frames_timeout
  );
endinterface

// File: rtl/kc705_ethernet_rx_decode_ctrl_sat_counter.sv
// kc705_sat_counter: saturating up-counter with synchronous clear taking priority over increment
module kc705_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q, count_d;
  // next count: clear wins, increment stops at all-ones
  always_comb count_d = clr_i ? '0 : (inc_i && !(&count_q)) ? count_q + 1'b1 : count_q;
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/kc705_ethernet_rx_decode_ctrl.sv
// kc705_ethernet_rx_decode_ctrl: arms the RX decoder frame by frame, watches for stalls and counts frames
module kc705_ethernet_rx_decode_ctrl
  import kc705_eth_ctrl_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096,
  parameter logic [3:0]  FLUSH_CYCLES   = 4'd4,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                            axi_tclk,
  input  logic                            axi_treset,
  kc705_ethernet_rx_decode_ctrl_if.slave  bus
);
  state_e               state_q, state_d;
  logic [23:0]          wdog_q, wdog_d, limit;
  logic [3:0]           flush_q, flush_d;
  logic                 stop_q, stop_d;
  logic                 en_q, rstn_q, busy_q, done_q;
  logic                 cnt_clr, ok_inc, to_inc;
  logic                 beat, stop_any;
  logic [CNT_WIDTH-1:0] ok_cnt, to_cnt, ok_next;
  state_e               end_state;
  assign beat      = bus.dec_tvalid & bus.dec_tready;
  assign limit     = {8'd0, TIMEOUT_CYCLES} << wdog_shift(bus.speed);
  assign ok_next   = &ok_cnt ? ok_cnt : ok_cnt + 1'b1;
  assign stop_any  = stop_q | bus.ctrl_stop;
  assign end_state = (bus.ctrl_num_frames != '0 && ok_next == bus.ctrl_num_frames) ? ST_DONE :
                     stop_any ? ST_IDLE : ST_ARM;
  // next-state, watchdog, flush timer and counter strobes
  always_comb begin
    state_d = state_q;
    wdog_d  = 24'd0;
    flush_d = 4'd0;
    stop_d  = stop_q;
    cnt_clr = 1'b0;
    ok_inc  = 1'b0;
    to_inc  = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.ctrl_start && !bus.ctrl_stop) begin
        state_d = ST_ARM;
        cnt_clr = 1'b1;
        stop_d  = 1'b0;
      end
      ST_ARM: begin
        state_d = stop_any ? ST_IDLE : ST_WAIT_FRAME;
        stop_d  = stop_any;
      end
      ST_WAIT_FRAME: if (bus.ctrl_stop) state_d = ST_IDLE;
      else if (beat && bus.dec_tlast) begin
        ok_inc  = 1'b1;
        state_d = end_state;
      end else if (beat) state_d = ST_IN_FRAME;
      ST_IN_FRAME: begin
        stop_d = stop_any;
        if (beat && bus.dec_tlast) begin
          ok_inc  = 1'b1;
          state_d = end_state;
        end else if (!beat && wdog_q == limit) begin
          to_inc  = 1'b1;
          state_d = ST_FLUSH;
        end else if (!beat) wdog_d = wdog_q + 24'd1;
      end
      ST_FLUSH: begin
        stop_d  = stop_any;
        flush_d = flush_q + 4'd1;
        if (flush_q == FLUSH_CYCLES - 4'd1) state_d = stop_any ? ST_IDLE : ST_ARM;
      end
      ST_DONE: if (bus.ctrl_stop) state_d = ST_IDLE;
      else if (bus.ctrl_start) begin
        state_d = ST_ARM;
        cnt_clr = 1'b1;
        stop_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state, watchdog and flush timer registers
  always_ff @(posedge axi_tclk or posedge axi_treset)
    if (axi_treset) begin
      state_q <= ST_IDLE;
      wdog_q  <= 24'd0;
      flush_q <= 4'd0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      flush_q <= flush_d;
      stop_q  <= stop_d;
    end
  // outputs decoded from the next state so they line up with the state they describe
  always_ff @(posedge axi_tclk or posedge axi_treset)
    if (axi_treset) begin
      en_q   <= 1'b0;
      rstn_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      en_q   <= state_d == ST_WAIT_FRAME;
      rstn_q <= state_d != ST_FLUSH;
      busy_q <= !(state_d == ST_IDLE || state_d == ST_DONE);
      done_q <= state_d == ST_DONE;
    end
  kc705_sat_counter #(.WIDTH(CNT_WIDTH)) u_ok (
    .clk(axi_tclk), .rst(axi_treset), .clr_i(cnt_clr), .inc_i(ok_inc), .count_o(ok_cnt)
  );
  kc705_sat_counter #(.WIDTH(CNT_WIDTH)) u_to (
    .clk(axi_tclk), .rst(axi_treset), .clr_i(cnt_clr), .inc_i(to_inc), .count_o(to_cnt)
  );
  assign bus.enable_rx_decode = en_q;
  assign bus.decoder_resetn   = rstn_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.frames_ok        = ok_cnt;
  assign bus.frames_timeout   = to_cnt;
endmodule

// File: tb/tb_kc705_ethernet_rx_decode_ctrl.sv
// tb_kc705_ethernet_rx_decode_ctrl: scenario bench with a counter-update scoreboard
module tb_kc705_ethernet_rx_decode_ctrl;
  typedef struct { int ok; int to; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   ok_m = 0;
  int   to_m = 0;
  exp_t sb[$];
  logic [15:0] prev_ok = '0;
  logic [15:0] prev_to = '0;
  kc705_ethernet_rx_decode_ctrl_if #(.CNT_WIDTH(16)) bus ();
  kc705_ethernet_rx_decode_ctrl #(.TIMEOUT_CYCLES(16'd16), .FLUSH_CYCLES(4'd4), .CNT_WIDTH(16)) dut (
    .axi_tclk(clk), .axi_treset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  // every counter increment must match the oldest expected counter pair
  always @(negedge clk) begin
    if (!rst && (bus.frames_ok > prev_ok || bus.frames_timeout > prev_to)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected ok=%0d to=%0d with nothing expected", bus.frames_ok, bus.frames_timeout);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (int'(bus.frames_ok) !== e.ok || int'(bus.frames_timeout) !== e.to) begin
          bad++;
          $display("FAIL sb_counters got ok=%0d to=%0d want ok=%0d to=%0d", bus.frames_ok, bus.frames_timeout, e.ok, e.to);
        end
      end
    end
    prev_ok = bus.frames_ok;
    prev_to = bus.frames_timeout;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    bus.ctrl_start = 1'b1;
    tick();
    bus.ctrl_start = 1'b0;
  endtask
  task automatic pulse_stop();
    bus.ctrl_stop = 1'b1;
    tick();
    bus.ctrl_stop = 1'b0;
  endtask
  task automatic drive_frame(input int nbeats, input bit with_last, input int stop_at);
    int n = 0;
    while (bus.enable_rx_decode !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (bus.enable_rx_decode !== 1'b1) begin
      bad++;
      $display("FAIL wait_frame_enable got=%b want=1", bus.enable_rx_decode);
    end
    for (int i = 0; i < nbeats; i++) begin
      bus.dec_tvalid = 1'b1;
      bus.dec_tready = 1'b1;
      bus.dec_tlast  = with_last && i == nbeats - 1;
      bus.ctrl_stop  = i == stop_at;
      if (bus.dec_tlast) begin
        ok_m++;
        sb.push_back('{ok_m, to_m});
      end
      tick();
      bus.ctrl_stop = 1'b0;
      if (i == 0 && nbeats > 1) begin
        total++;
        if (bus.enable_rx_decode !== 1'b0) begin
          bad++;
          $display("FAIL in_frame_enable got=%b want=0", bus.enable_rx_decode);
        end
      end
    end
    bus.dec_tvalid = 1'b0;
    bus.dec_tlast  = 1'b0;
  endtask
  task automatic test_reset();
    bus.speed = 2'b10;
    bus.ctrl_start = 1'b0;
    bus.ctrl_stop = 1'b0;
    bus.ctrl_num_frames = '0;
    bus.dec_tvalid = 1'b0;
    bus.dec_tlast = 1'b0;
    bus.dec_tready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    total++;
    if ({bus.enable_rx_decode, bus.decoder_resetn, bus.busy, bus.done} !== 4'b0100) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0100", {bus.enable_rx_decode, bus.decoder_resetn, bus.busy, bus.done});
    end
    total++;
    if (bus.frames_ok !== 16'd0 || bus.frames_timeout !== 16'd0) begin
      bad++;
      $display("FAIL reset_counters got ok=%0d to=%0d want 0 0", bus.frames_ok, bus.frames_timeout);
    end
  endtask
  task automatic test_count_limit();
    bus.speed = 2'b10;
    bus.ctrl_num_frames = 16'd3;
    pulse_start();
    ok_m = 0;
    to_m = 0;
    for (int f = 0; f < 3; f++) drive_frame(10, 1'b1, -1);
    total++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      bad++;
      $display("FAIL limit_done got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
    end
    total++;
    if (bus.frames_ok !== 16'd3 || bus.frames_timeout !== 16'd0) begin
      bad++;
      $display("FAIL limit_counters got ok=%0d to=%0d want 3 0", bus.frames_ok, bus.frames_timeout);
    end
    repeat (5) tick();
    total++;
    if (bus.enable_rx_decode !== 1'b0 || bus.done !== 1'b1) begin
      bad++;
      $display("FAIL limit_hold got en=%b done=%b want en=0 done=1", bus.enable_rx_decode, bus.done);
    end
  endtask
  task automatic test_stall(input logic [1:0] spd, input int limit);
    int n = 0;
    int low = 0;
    if (bus.busy) pulse_stop();
    bus.speed = spd;
    bus.ctrl_num_frames = '0;
    pulse_start();
    ok_m = 0;
    to_m = 0;
    drive_frame(3, 1'b0, -1);
    to_m++;
    sb.push_back('{ok_m, to_m});
    while (n < limit + 50) begin
      tick();
      n++;
      if (bus.decoder_resetn === 1'b0) break;
    end
    total++;
    if (n !== limit + 1) begin
      bad++;
      $display("FAIL stall_latency spd=%b got=%0d want=%0d", spd, n, limit + 1);
    end
    while (bus.decoder_resetn === 1'b0 && low < 20) begin
      low++;
      tick();
    end
    total++;
    if (low !== 4) begin
      bad++;
      $display("FAIL flush_len got=%0d want=4", low);
    end
    tick();
    total++;
    if (bus.enable_rx_decode !== 1'b1 || bus.frames_timeout !== 16'd1) begin
      bad++;
      $display("FAIL stall_rearm got en=%b to=%0d want en=1 to=1", bus.enable_rx_decode, bus.frames_timeout);
    end
  endtask
  task automatic test_graceful_stop();
    int highs = 0;
    pulse_stop();
    bus.speed = 2'b10;
    bus.ctrl_num_frames = '0;
    pulse_start();
    ok_m = 0;
    to_m = 0;
    drive_frame(10, 1'b1, 4);
    total++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.frames_ok !== 16'd1) begin
      bad++;
      $display("FAIL stop_idle got busy=%b done=%b ok=%0d want 0 0 1", bus.busy, bus.done, bus.frames_ok);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.enable_rx_decode || bus.busy) highs++;
    end
    total++;
    if (highs !== 0) begin
      bad++;
      $display("FAIL stop_no_rearm got=%0d active cycles want=0", highs);
    end
  endtask
  task automatic test_collision();
    bus.ctrl_start = 1'b1;
    bus.ctrl_stop = 1'b1;
    tick();
    bus.ctrl_start = 1'b0;
    bus.ctrl_stop = 1'b0;
    repeat (3) tick();
    total++;
    if (bus.busy !== 1'b0 || bus.enable_rx_decode !== 1'b0 || bus.frames_ok !== 16'd1) begin
      bad++;
      $display("FAIL collision_idle got busy=%b en=%b ok=%0d want 0 0 1", bus.busy, bus.enable_rx_decode, bus.frames_ok);
    end
    pulse_start();
    ok_m = 0;
    to_m = 0;
    drive_frame(1, 1'b1, -1);
    tick();
    pulse_start();
    tick();
    total++;
    if (bus.frames_ok !== 16'd1 || bus.busy !== 1'b1 || bus.enable_rx_decode !== 1'b1) begin
      bad++;
      $display("FAIL busy_start got ok=%0d busy=%b en=%b want 1 1 1", bus.frames_ok, bus.busy, bus.enable_rx_decode);
    end
  endtask
  task automatic test_async_reset_flush();
    int n = 0;
    drive_frame(2, 1'b0, -1);
    to_m++;
    sb.push_back('{ok_m, to_m});
    while (bus.decoder_resetn !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.enable_rx_decode, bus.decoder_resetn, bus.busy, bus.done} !== 4'b0100) begin
      bad++;
      $display("FAIL async_flags got=%b want=0100", {bus.enable_rx_decode, bus.decoder_resetn, bus.busy, bus.done});
    end
    total++;
    if (bus.frames_ok !== 16'd0 || bus.frames_timeout !== 16'd0) begin
      bad++;
      $display("FAIL async_counters got ok=%0d to=%0d want 0 0", bus.frames_ok, bus.frames_timeout);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_count_limit();
    test_stall(2'b10, 16);
    test_stall(2'b01, 256);
    test_stall(2'b00, 2048);
    test_graceful_stop();
    test_collision();
    test_async_reset_flush();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d pending want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
